// File: rtl/qa_drv_read_buffer.sv
// Read-request register and response FIFO between a client and the QA memory driver.
// Credits bound in-flight reads plus buffered responses so responses can never overflow the FIFO.
module qa_drv_read_buffer #(
    parameter int CCI_ADDR_WIDTH = 32,
    parameter int CCI_DATA_WIDTH = 512,
    parameter int N_ENTRIES      = 16,
    parameter bit FATAL_ON_ERR   = 1'b1
) (
    input  logic                          clk,
    input  logic                          resetb,
    input  logic [CCI_ADDR_WIDTH-1:0]     rd_req_addr,
    input  logic                          rd_req_enable,
    output logic                          rd_req_rdy,
    output logic [CCI_DATA_WIDTH-1:0]     rd_rsp_data,
    output logic                          rd_rsp_valid,
    input  logic                          rd_rsp_deq,
    output logic [CCI_ADDR_WIDTH-1:0]     mem_read_req_addr,
    output logic                          mem_read_req_enable,
    input  logic                          mem_read_req_rdy,
    input  logic [CCI_DATA_WIDTH-1:0]     mem_read_rsp_data,
    input  logic                          mem_read_rsp_rdy,
    output logic [$clog2(N_ENTRIES):0]    rd_outstanding,
    output logic                          err_sticky
);

    localparam int CW = $clog2(N_ENTRIES) + 1;
    localparam int PW = $clog2(N_ENTRIES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] v,
                                               input logic up, input logic dn);
        case ({up, dn})
            2'b10:   return v + CNT_ONE;
            2'b01:   return v - CNT_ONE;
            default: return v;
        endcase
    endfunction

    logic                      req_vld_p0;
    logic [CCI_ADDR_WIDTH-1:0] req_addr_p0;
    logic [CW-1:0]             credits;
    logic [CW-1:0]             outstanding;
    logic [CW-1:0]             fifo_count;
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [CCI_DATA_WIDTH-1:0] mem [N_ENTRIES];

    logic accept, issue, deq_fire, rsp_fire;
    logic req_err, deq_err, rsp_err;

    // Reset gates readiness so nothing is accepted while resetb is low.
    assign rd_req_rdy          = resetb && (!req_vld_p0 || mem_read_req_rdy) && (credits != '0);
    assign accept              = rd_req_enable && rd_req_rdy;
    assign issue               = req_vld_p0 && mem_read_req_rdy;
    assign mem_read_req_enable = issue;
    assign mem_read_req_addr   = req_addr_p0;

    assign rd_rsp_valid = (fifo_count != '0);
    assign rd_rsp_data  = mem[rd_ptr];
    assign deq_fire     = rd_rsp_deq && rd_rsp_valid;
    assign rsp_fire     = mem_read_rsp_rdy && (outstanding != '0);

    assign req_err = rd_req_enable && !rd_req_rdy;
    assign deq_err = rd_rsp_deq && !rd_rsp_valid;
    assign rsp_err = mem_read_rsp_rdy && (outstanding == '0);

    assign rd_outstanding = outstanding;

    // Stage p0: one-entry request register; reload on accept even while issuing.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            req_vld_p0 <= 1'b0;
        end else if (accept) begin
            req_vld_p0 <= 1'b1;
        end else if (issue) begin
            req_vld_p0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr_p0 <= rd_req_addr;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            credits     <= CW'(N_ENTRIES);
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            err_sticky  <= 1'b0;
        end else begin
            credits     <= cnt_step(credits, deq_fire, accept);
            outstanding <= cnt_step(outstanding, issue, rsp_fire);
            fifo_count  <= cnt_step(fifo_count, rsp_fire, deq_fire);
            if (rsp_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (req_err || deq_err || rsp_err) begin
                err_sticky <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_fire) begin
            mem[wr_ptr] <= mem_read_rsp_data;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetb && FATAL_ON_ERR) begin
            assert (!req_err) else $fatal(1, "qa_drv_read_buffer: rd_req_enable while not ready");
            assert (!deq_err) else $fatal(1, "qa_drv_read_buffer: rd_rsp_deq while empty");
            assert (!rsp_err) else $fatal(1, "qa_drv_read_buffer: response with nothing outstanding");
        end
    end
`endif

endmodule

// File: tb/tb_qa_drv_read_buffer.sv
// Bench for qa_drv_read_buffer: directed steps then random traffic against a queue-based model.
module tb_qa_drv_read_buffer;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          resetb;
    logic [AW-1:0] rd_req_addr;
    logic          rd_req_enable;
    logic          rd_req_rdy;
    logic [DW-1:0] rd_rsp_data;
    logic          rd_rsp_valid;
    logic          rd_rsp_deq;
    logic [AW-1:0] mem_read_req_addr;
    logic          mem_read_req_enable;
    logic          mem_read_req_rdy;
    logic [DW-1:0] mem_read_rsp_data;
    logic          mem_read_rsp_rdy;
    logic [$clog2(N):0] rd_outstanding;
    logic          err_sticky;

    qa_drv_read_buffer #(
        .CCI_ADDR_WIDTH(AW),
        .CCI_DATA_WIDTH(DW),
        .N_ENTRIES(N),
        .FATAL_ON_ERR(1'b0)
    ) dut (
        .clk(clk),
        .resetb(resetb),
        .rd_req_addr(rd_req_addr),
        .rd_req_enable(rd_req_enable),
        .rd_req_rdy(rd_req_rdy),
        .rd_rsp_data(rd_rsp_data),
        .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_deq(rd_rsp_deq),
        .mem_read_req_addr(mem_read_req_addr),
        .mem_read_req_enable(mem_read_req_enable),
        .mem_read_req_rdy(mem_read_req_rdy),
        .mem_read_rsp_data(mem_read_rsp_data),
        .mem_read_rsp_rdy(mem_read_rsp_rdy),
        .rd_outstanding(rd_outstanding),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pending request, in-flight count, buffered responses, free credits.
    logic [AW-1:0] m_req[$];
    logic [DW-1:0] m_fifo[$];
    int            m_out;
    int            m_credits;
    bit            m_err;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req.delete();
        m_fifo.delete();
        m_out     = 0;
        m_credits = N;
        m_err     = 1'b0;
    endtask

    function automatic bit model_rdy(input bit mr);
        return (m_req.size() == 0 || mr) && m_credits > 0;
    endfunction

    // One clock: drive at posedge+1, check at posedge+2, advance model on the edge.
    task automatic step(input bit en, input logic [AW-1:0] a, input bit dq,
                        input bit mr, input bit rs, input logic [DW-1:0] d);
        bit m_rdy, m_iss;
        int fifo_pre, out_pre;
        rd_req_enable     = en;
        rd_req_addr       = a;
        rd_rsp_deq        = dq;
        mem_read_req_rdy  = mr;
        mem_read_rsp_rdy  = rs;
        mem_read_rsp_data = d;
        #1;
        m_rdy    = model_rdy(mr);
        m_iss    = (m_req.size() != 0) && mr;
        fifo_pre = m_fifo.size();
        out_pre  = m_out;
        check("rd_req_rdy", DW'(rd_req_rdy), DW'(m_rdy));
        check("rd_rsp_valid", DW'(rd_rsp_valid), DW'(fifo_pre != 0));
        if (fifo_pre != 0) check("rd_rsp_data", rd_rsp_data, m_fifo[0]);
        check("mem_read_req_enable", DW'(mem_read_req_enable), DW'(m_iss));
        if (m_iss) check("mem_read_req_addr", DW'(mem_read_req_addr), DW'(m_req[0]));
        check("rd_outstanding", DW'(rd_outstanding), DW'(out_pre));
        check("err_sticky", DW'(err_sticky), DW'(m_err));
        @(posedge clk);
        if (m_iss) begin
            void'(m_req.pop_front());
            m_out++;
        end
        if (en) begin
            if (m_rdy) begin
                m_req.push_back(a);
                m_credits--;
            end else m_err = 1'b1;
        end
        if (dq) begin
            if (fifo_pre != 0) begin
                void'(m_fifo.pop_front());
                m_credits++;
            end else m_err = 1'b1;
        end
        if (rs) begin
            if (out_pre > 0) begin
                m_fifo.push_back(d);
                m_out--;
            end else m_err = 1'b1;
        end
        #1;
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (m_out == 0 && m_req.size() == 0 && m_fifo.size() == 0) break;
            step(1'b0, '0, m_fifo.size() != 0, 1'b1, m_out > 0, rnd64());
        end
        check("drain_outstanding", DW'(rd_outstanding), '0);
        check("drain_valid", DW'(rd_rsp_valid), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb = 1'b0;
        rd_req_enable = 0; rd_req_addr = '0; rd_rsp_deq = 0;
        mem_read_req_rdy = 1; mem_read_rsp_rdy = 0; mem_read_rsp_data = '0;
        model_reset();
        #22;
        check("reset_rdy", DW'(rd_req_rdy), '0);
        check("reset_valid", DW'(rd_rsp_valid), '0);
        check("reset_req_en", DW'(mem_read_req_enable), '0);
        check("reset_outstanding", DW'(rd_outstanding), '0);
        check("reset_err", DW'(err_sticky), '0);
        resetb = 1'b1;
        @(posedge clk); #1;

        // Single read
        step(1, 32'h100, 0, 1, 0, '0);
        step(0, '0, 0, 1, 0, '0);
        check("single_outstanding", DW'(rd_outstanding), 1);
        step(0, '0, 0, 1, 1, {8{8'hA5}});
        check("single_valid", DW'(rd_rsp_valid), 1);
        check("single_data", rd_rsp_data, {8{8'hA5}});
        step(0, '0, 1, 1, 0, '0);
        check("single_empty", DW'(rd_rsp_valid), '0);

        // Credit exhaustion
        for (int i = 0; i < N; i++) step(1, 32'h1000 + i, 0, 1, 0, '0);
        step(0, '0, 0, 1, 0, '0);
        check("exhaust_rdy", DW'(rd_req_rdy), '0);
        for (int i = 0; i < N; i++) step(0, '0, 0, 1, 1, rnd64());
        check("exhaust_rdy_full", DW'(rd_req_rdy), '0);
        step(0, '0, 1, 1, 0, '0);
        check("credit_return_rdy", DW'(rd_req_rdy), 1);
        step(1, 32'h2000, 0, 1, 0, '0);
        check("credit_again_empty", DW'(rd_req_rdy), '0);
        drain();

        // Driver stall with one request held
        step(1, 32'h200, 0, 0, 0, '0);
        for (int i = 0; i < 10; i++) step(0, '0, 0, 0, 0, '0);
        check("stall_rdy", DW'(rd_req_rdy), '0);
        check("stall_issue", DW'(mem_read_req_enable), '0);
        check("stall_outstanding", DW'(rd_outstanding), '0);
        step(1, 32'h204, 0, 1, 0, '0);
        step(0, '0, 0, 1, 0, '0);
        drain();

        // Near-full FIFO, simultaneous deq+response, order across pointer wrap
        for (int i = 0; i < N; i++) step(1, 32'h300 + i, 0, 1, 0, '0);
        step(0, '0, 0, 1, 0, '0);
        for (int i = 0; i < N - 1; i++) step(0, '0, 0, 1, 1, rnd64());
        step(0, '0, 1, 1, 1, rnd64());
        check("simul_outstanding", DW'(rd_outstanding), '0);
        step(1, 32'h400, 0, 1, 0, '0);
        step(0, '0, 0, 1, 0, '0);
        step(0, '0, 0, 1, 1, rnd64());
        check("full_rdy", DW'(rd_req_rdy), '0);
        step(0, '0, 1, 1, 0, '0);
        drain();

        // Random legal traffic
        for (int i = 0; i < 300; i++) begin
            bit mr;
            mr = ($urandom % 4) != 0;
            step(model_rdy(mr) && $urandom_range(0, 1), $urandom, m_fifo.size() != 0 && $urandom_range(0, 1),
                 mr, m_out > 0 && $urandom_range(0, 1), rnd64());
        end
        drain();

        // Protocol errors
        step(0, '0, 1, 1, 0, '0);
        check("deq_empty_err", DW'(err_sticky), 1);
        check("deq_empty_valid", DW'(rd_rsp_valid), '0);
        step(0, '0, 0, 1, 1, rnd64());
        check("stray_rsp_valid", DW'(rd_rsp_valid), '0);
        check("stray_rsp_outstanding", DW'(rd_outstanding), '0);
        step(1, 32'h500, 0, 1, 0, '0);
        step(0, '0, 0, 1, 0, '0);
        step(0, '0, 0, 1, 1, 64'h0123_4567_89AB_CDEF);
        check("after_err_data", rd_rsp_data, 64'h0123_4567_89AB_CDEF);
        drain();

        // Async reset mid-burst with three reads outstanding
        step(1, 32'h600, 0, 1, 0, '0);
        step(1, 32'h604, 0, 1, 0, '0);
        step(1, 32'h608, 0, 1, 0, '0);
        step(1, 32'h60C, 0, 1, 1, rnd64());
        step(0, '0, 0, 1, 0, '0);
        check("burst_outstanding", DW'(rd_outstanding), 3);
        check("burst_valid", DW'(rd_rsp_valid), 1);
        rd_req_enable = 0; rd_rsp_deq = 0; mem_read_req_rdy = 1; mem_read_rsp_rdy = 0;
        #2;
        resetb = 1'b0;
        #1;
        check("async_rdy", DW'(rd_req_rdy), '0);
        check("async_valid", DW'(rd_rsp_valid), '0);
        check("async_req_en", DW'(mem_read_req_enable), '0);
        check("async_outstanding", DW'(rd_outstanding), '0);
        check("async_err", DW'(err_sticky), '0);
        #1;
        resetb = 1'b1;
        model_reset();
        @(posedge clk); #1;
        step(0, '0, 0, 1, 1, rnd64());
        check("stale_rsp_err", DW'(err_sticky), 1);
        check("stale_rsp_valid", DW'(rd_rsp_valid), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
